// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU extension execute-stage sequencer.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } fpu_seq_state_t;

    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_SUB = 2'd1,
        FU_MUL = 2'd2,
        FU_DIV = 2'd3
    } fu_op_t;

    localparam logic [6:0] FUNCT7_FADD = 7'b0000000;
    localparam logic [6:0] FUNCT7_FSUB = 7'b0000100;
    localparam logic [6:0] FUNCT7_FMUL = 7'b0001000;
    localparam logic [6:0] FUNCT7_FDIV = 7'b0001100;

    localparam logic [2:0] RM_DYN = 3'b111;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Encodings 101..111 are reserved once the dynamic mode has been resolved.
    function automatic logic rm_is_legal(input logic [2:0] rm);
        return rm < 3'd5;
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the instruction rounding mode against fcsr.frm and flags reserved results.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [2:0] frm_insn,
    input  logic [2:0] csr_frm,
    output logic [2:0] rm,
    output logic       rm_illegal
);

    always_comb begin
        rm         = (frm_insn == RM_DYN) ? csr_frm : frm_insn;
        rm_illegal = !rm_is_legal(rm);
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Execute-stage sequencer: issues FP arithmetic to the shared unit or FLW/FSW to the
// memory port, generates the FP register-file write and accrues fflags.
module fpu_seq_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned ADD_LAT = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 12,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [6:0]  funct7,
    input  logic [2:0]  frm_insn,
    input  logic        load,
    input  logic        store,
    input  logic [4:0]  rd,
    input  logic [11:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] fs2_data,
    input  logic [2:0]  csr_frm,
    input  logic        fflags_clear,
    input  logic [4:0]  fu_flags,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        fu_start,
    output logic [1:0]  fu_op,
    output logic [2:0]  fu_rm,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        frf_wen,
    output logic [4:0]  frf_waddr,
    output logic        frf_sel_mem,
    output logic [4:0]  fflags
);

    fpu_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fu_op_t           op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    logic             is_load_q, is_load_d;
    logic             is_store_q, is_store_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    fflags_t          fflags_q, fflags_d;

    fu_op_t           dec_op;
    logic             funct7_ok;
    logic [CNT_W-1:0] lat_m1;
    logic [2:0]       res_rm;
    logic             rm_bad;
    logic             idle, is_mem, issue_bad, issue_ok, issue_arith, wb_arith;
    logic [4:0]       flags_kept;

    // Load data is muxed into the register file downstream; only the select is made here.
    logic mem_rdata_unused;
    assign mem_rdata_unused = ^mem_rdata;

    fpu_rm_resolve u_rm_resolve (
        .frm_insn   (frm_insn),
        .csr_frm    (csr_frm),
        .rm         (res_rm),
        .rm_illegal (rm_bad)
    );

    always_comb begin
        funct7_ok = 1'b1;
        dec_op    = FU_ADD;
        unique case (funct7)
            FUNCT7_FADD: dec_op = FU_ADD;
            FUNCT7_FSUB: dec_op = FU_SUB;
            FUNCT7_FMUL: dec_op = FU_MUL;
            FUNCT7_FDIV: dec_op = FU_DIV;
            default:     funct7_ok = 1'b0;
        endcase
        unique case (dec_op)
            FU_MUL:  lat_m1 = CNT_W'(MUL_LAT - 1);
            FU_DIV:  lat_m1 = CNT_W'(DIV_LAT - 1);
            default: lat_m1 = CNT_W'(ADD_LAT - 1);
        endcase
    end

    always_comb begin
        idle        = (state_q == IDLE);
        is_mem      = load || store;
        issue_bad   = idle && start && ((load && store) || (!is_mem && (!funct7_ok || rm_bad)));
        issue_ok    = idle && start && !issue_bad;
        issue_arith = issue_ok && !is_mem;
        wb_arith    = (state_q == WB) && !is_load_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rm_d       = rm_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        flags_kept = fflags_clear ? 5'b0 : fflags_q;
        fflags_d   = fflags_t'(flags_kept | (wb_arith ? fu_flags : 5'b0));

        unique case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    is_load_d  = load;
                    is_store_d = store;
                    if (load) begin
                        addr_d  = rs1_data + {{20{imm[11]}}, imm};
                        rd_d    = rd;
                        state_d = MEM;
                    end else if (store) begin
                        addr_d  = rs1_data + {{20{imm[11]}}, imm};
                        wdata_d = fs2_data;
                        state_d = MEM;
                    end else begin
                        op_d    = dec_op;
                        rm_d    = res_rm;
                        rd_d    = rd;
                        cnt_d   = lat_m1;
                        // Result is valid LAT cycles after launch, so a 1-cycle op skips EXEC.
                        state_d = (lat_m1 == '0) ? WB : EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (!mem_busy) begin
                    state_d = is_load_q ? WB : IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= FU_ADD;
            rm_q       <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            rd_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fflags_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fflags_q   <= fflags_d;
        end
    end

    // Issue-cycle outputs come straight from decode so the stall and launch land in that cycle.
    always_comb begin
        busy        = idle ? issue_ok : 1'b1;
        illegal     = issue_bad;
        fu_start    = issue_arith;
        fu_op       = '0;
        fu_rm       = '0;
        if (issue_arith) begin
            fu_op = dec_op;
            fu_rm = res_rm;
        end else if (state_q == EXEC || state_q == WB) begin
            fu_op = op_q;
            fu_rm = rm_q;
        end
        done        = (state_q == WB) || ((state_q == MEM) && is_store_q && !mem_busy);
        mem_ren     = (state_q == MEM) && is_load_q;
        mem_wen     = (state_q == MEM) && is_store_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        frf_wen     = (state_q == WB);
        frf_waddr   = rd_q;
        frf_sel_mem = (state_q == WB) && is_load_q;
        fflags      = fflags_q;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
Sequencing controller for the RISC-MGMT FPU extension's execute stage.
- Accepts one decoded FPU operation per issue (arithmetic, FLW or FSW) from the FPU decode stage.
- Drives the shared multi-cycle FP arithmetic unit and the extension's memory port, and generates the FP register-file write.
- Accumulates fflags.
- Stalls the core pipeline through busy until the operation retires.

Parameters:
ADD_LAT, 3, cycles from fu_start to result valid for add/sub (>=1)
MUL_LAT, 4, cycles for mul (>=1)
DIV_LAT, 12, cycles for div (>=1)
CNT_W, 4, down-counter width; must satisfy 2^CNT_W > max latency

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
start  in  1  decode claims a valid FPU instruction this cycle
funct7  in  7  arithmetic function code
frm_insn  in  3  rounding mode field from the instruction
load  in  1  instruction is FLW
store  in  1  instruction is FSW
rd  in  5  FP destination register
imm  in  12  load/store offset
rs1_data  in  32  integer base address
fs2_data  in  32  FP store data
csr_frm  in  3  dynamic rounding mode from fcsr
fflags_clear  in  1  CSR write clears fflags
fu_flags  in  5  exception flags from the arithmetic unit, valid with result
mem_busy  in  1  memory port not ready; request held while high
mem_rdata  in  32  load data
busy  out  1  pipeline stall
done  out  1  one-cycle retire pulse
illegal  out  1  one-cycle illegal-instruction pulse
fu_start  out  1  one-cycle launch pulse to the arithmetic unit
fu_op  out  2  0=add 1=sub 2=mul 3=div
fu_rm  out  3  resolved rounding mode
mem_ren  out  1  load request
mem_wen  out  1  store request
mem_addr  out  32  rs1_data + sign-extended imm, latched at issue
mem_wdata  out  32  fs2_data, latched at issue
frf_wen  out  1  FP register-file write enable
frf_waddr  out  5  latched rd
frf_sel_mem  out  1  write-back mux select: 1=mem_rdata, 0=unit result
fflags  out  5  accrued exception flags (NV DZ OF UF NX)

Behaviour:
Reset:
- Every output is 0; FSM state is IDLE; fflags = 0; counter = 0.
- nRST asserted mid-operation aborts the operation with no write-back and no done.

funct7 decode:
- 0000000 = add, 0000100 = sub, 0001000 = mul, 0001100 = div.
- Any other code is illegal.

Rounding mode resolution:
- rm = frm_insn, except frm_insn = 111, which selects csr_frm.
- Resolved rm of 101, 110 or 111 is illegal.

FSM IDLE (accepts start):
- load: latch addr and rd, go to MEM.
- store: latch addr and wdata, go to MEM.
- Legal arithmetic: fu_start = 1 for this cycle; drive fu_op and fu_rm; counter = LAT-1; go to EXEC.
- Illegal: illegal = 1 for one cycle; stay in IDLE; no write, no done.
- load and store both high: treated as illegal.
- busy = start in IDLE (legal case only), and busy is 1 in every other state. The stall therefore takes effect in the issue cycle.

FSM EXEC:
- Decrement the counter each cycle.
- When the counter is 0, go to WB. The unit result is sampled in WB.
- fu_op and fu_rm are held stable throughout EXEC.
- Total arithmetic occupancy is LAT+1 cycles, from issue to done.

FSM MEM:
- mem_ren or mem_wen stays high until a cycle with mem_busy = 0.
- Load: that cycle captures, go to WB with frf_sel_mem = 1.
- Store: done = 1 in that cycle, go to IDLE.

FSM WB (exactly one cycle):
- frf_wen = 1 and done = 1, then go to IDLE.
- Arithmetic only: fflags |= fu_flags.

fflags update:
- next = (fflags_clear ? 0 : fflags) | (WB & arithmetic ? fu_flags : 0).
- A clear in the same cycle as WB keeps the new flags.

Other rules:
- start outside IDLE is ignored; decode holds it under stall.
- mem_addr is computed at issue with 32-bit wrap-around and no alignment check.

Decomposition:
- fpu_pkg gains: the fpu_seq_state_t enum (IDLE, EXEC, MEM, WB); the fu_op_t enum; the FUNCT7_FADD/FSUB/FMUL/FDIV constants; the RM_DYN = 3'b111 constant; and an fflags_t struct.
- Optional sub-module fpu_rm_resolve: combinational; computes the resolved rm and the illegal flag from frm_insn and csr_frm.

Test Plan:
1. FADD, frm_insn=000, fu_flags=00001 -> fu_start at cycle 0, fu_op=0, frf_wen and done at cycle 3, busy high cycles 0-3, fflags=00001.
2. FDIV with frm_insn=111, csr_frm=001 -> fu_rm=001, done at cycle 12. Same op with csr_frm=101 -> illegal pulse, busy=0, no fu_start.
3. FLW, rs1_data=0x1000, imm=0xFFC, mem_busy high for 2 cycles -> mem_addr=0x0FFC, mem_ren held 3 cycles, then frf_wen with frf_sel_mem=1, frf_waddr=rd.
4. FSW, rs1_data=0xFFFFFFF8, imm=0x010, mem_busy=0 -> mem_addr=0x00000008, mem_wen=1 for one cycle with done, no frf_wen.
5. fflags_clear in the same cycle as an FMUL WB with fu_flags=10000 -> fflags=10000. A later clear alone -> 00000.
6. nRST pulsed during EXEC of an FDIV -> all outputs 0 and no done. The next FSUB completes normally with done at cycle 3.
